// File: rtl/dmem_pkg.sv
// ---------------------------------------------------------------------------
// dmem_pkg
// Shared types and constants for the data-memory controller (data_mem_ctrl)
// and its storage array (dmem_array).
//
// Contents:
//   WORD_BYTES           bytes per doubleword (8)
//   BYTE_OFS_W           number of byte-offset address bits inside a word
//   DEFAULT_DEPTH        default number of words in the array
//   DEFAULT_WAIT_CYCLES  default extra access cycles before the response
//   WAIT_CNT_W           width of the wait-state counter (covers 0..15)
//   dmemStateT           controller FSM states {IDLE, ACCESS, RESP}
//   dmemOpT              decoded request operation {NOP, LOAD, STORE}
//   decodeOp()           MemRead/MemWrite -> operation, store has priority
// ---------------------------------------------------------------------------
package dmem_pkg;

    localparam int WORD_BYTES          = 8;
    localparam int BYTE_OFS_W          = $clog2(WORD_BYTES);
    localparam int DEFAULT_DEPTH       = 256;
    localparam int DEFAULT_WAIT_CYCLES = 2;
    localparam int WAIT_CNT_W          = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } dmemStateT;

    typedef enum logic [1:0] {
        OP_NOP   = 2'd0,
        OP_LOAD  = 2'd1,
        OP_STORE = 2'd2
    } dmemOpT;

    // A request with both strobes set is a store; neither set is a NOP.
    function automatic dmemOpT decodeOp(input logic memRead, input logic memWrite);
        dmemOpT op;
        if (memWrite) begin
            op = OP_STORE;
        end else if (memRead) begin
            op = OP_LOAD;
        end else begin
            op = OP_NOP;
        end
        return op;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// ---------------------------------------------------------------------------
// dmem_array
// DEPTH x n doubleword storage behind data_mem_ctrl. Synchronous write,
// combinational read. Contents are not reset.
//
// Ports:
//   Clk     in   1      rising-edge clock
//   WrEn    in   1      write Index with WrData on the next rising edge
//   Index   in   IDX_W  word index for both read and write
//   WrData  in   n      data to store
//   RdData  out  n      contents of word Index (combinational)
// ---------------------------------------------------------------------------
module dmem_array
    import dmem_pkg::*;
#(
    parameter int n     = 64,
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             Clk,
    input  logic             WrEn,
    input  logic [IDX_W-1:0] Index,
    input  logic [n-1:0]     WrData,
    output logic [n-1:0]     RdData
);

    logic [n-1:0] memWords [DEPTH];

    always_ff @(posedge Clk) begin
        if (WrEn) begin
            memWords[Index] <= WrData;
        end
    end

    assign RdData = memWords[Index];

endmodule

// File: rtl/data_mem_ctrl.sv
// ---------------------------------------------------------------------------
// data_mem_ctrl
// Multi-cycle data-memory controller for LDUR/STUR. Accepts one request via a
// valid/ready handshake, spends WAIT_CYCLES+1 cycles in ACCESS, performs the
// doubleword read or write on the ACCESS->RESP edge and then pulses RespValid
// for one cycle in RESP before returning to IDLE.
//
// Build option:
//   DMEM_ALIGN_CHECK_EN  when defined, a request whose byte address is not
//                        doubleword aligned leaves the array and ReadData
//                        untouched and raises AlignErr with RespValid. When
//                        undefined, Address[2:0] is ignored and AlignErr is 0.
//
// Ports:
//   Clk        in   1  rising-edge clock
//   Rst_n      in   1  asynchronous active-low reset
//   ReqValid   in   1  request present this cycle
//   ReqReady   out  1  request can be accepted (IDLE only)
//   MemRead    in   1  request is a load
//   MemWrite   in   1  request is a store (wins over MemRead)
//   Address    in   n  byte address
//   WriteData  in   n  store data
//   RespValid  out  1  one-cycle completion pulse
//   ReadData   out  n  last load result
//   Busy       out  1  high outside IDLE
//   AlignErr   out  1  misaligned-access flag, valid with RespValid
// ---------------------------------------------------------------------------
module data_mem_ctrl
    import dmem_pkg::*;
#(
    parameter int n           = 64,
    parameter int DEPTH       = DEFAULT_DEPTH,
    parameter int WAIT_CYCLES = DEFAULT_WAIT_CYCLES
) (
    input  logic         Clk,
    input  logic         Rst_n,
    input  logic         ReqValid,
    output logic         ReqReady,
    input  logic         MemRead,
    input  logic         MemWrite,
    input  logic [n-1:0] Address,
    input  logic [n-1:0] WriteData,
    output logic         RespValid,
    output logic [n-1:0] ReadData,
    output logic         Busy,
    output logic         AlignErr
);

    localparam int IDX_W   = $clog2(DEPTH);
    localparam int IDX_LSB = BYTE_OFS_W;
    localparam int IDX_MSB = IDX_LSB + IDX_W - 1;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    dmemStateT               stateReg;
    logic [WAIT_CNT_W-1:0]   waitCntReg;
    dmemOpT                  opReg;
    logic [IDX_W-1:0]        indexReg;
    logic [n-1:0]            dataReg;
    logic                    misalignReg;
    logic                    reqReadyReg;
    logic                    busyReg;
    logic                    respValidReg;
    logic [n-1:0]            readDataReg;
    logic                    alignErrReg;

    // ------------------------------------------------------------------
    // Array interface
    // ------------------------------------------------------------------
    logic                    arrWrEn;
    logic [n-1:0]            arrRdData;
    logic                    accessDone;
    logic                    reqMisaligned;

    // Only the word-index bits of Address matter; upper bits wrap the
    // address space, and the byte offset is either ignored or only used for
    // the alignment check.
    logic                    unusedAddrBits;
    assign unusedAddrBits = ^{Address[n-1:IDX_MSB+1], Address[IDX_LSB-1:0]};

`ifdef DMEM_ALIGN_CHECK_EN
    assign reqMisaligned = (Address[IDX_LSB-1:0] != '0);
`else
    assign reqMisaligned = 1'b0;
`endif

    // The last ACCESS cycle: the counter has run down and the next edge
    // performs the array operation and enters RESP.
    assign accessDone = (stateReg == ACCESS) && (waitCntReg == '0);

    // Gated by state, so an asynchronous reset mid-access kills the write.
    assign arrWrEn = accessDone && (opReg == OP_STORE) && !misalignReg;

    dmem_array #(
        .n     (n),
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) uArray (
        .Clk    (Clk),
        .WrEn   (arrWrEn),
        .Index  (indexReg),
        .WrData (dataReg),
        .RdData (arrRdData)
    );

    // ------------------------------------------------------------------
    // FSM with registered outputs. ReqReady/Busy are updated alongside the
    // state so they are pure functions of the current state.
    // ------------------------------------------------------------------
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            stateReg     <= IDLE;
            waitCntReg   <= '0;
            opReg        <= OP_NOP;
            indexReg     <= '0;
            dataReg      <= '0;
            misalignReg  <= 1'b0;
            reqReadyReg  <= 1'b1;
            busyReg      <= 1'b0;
            respValidReg <= 1'b0;
            readDataReg  <= '0;
            alignErrReg  <= 1'b0;
        end else begin
            case (stateReg)
                IDLE: begin
                    respValidReg <= 1'b0;
                    alignErrReg  <= 1'b0;
                    if (ReqValid && reqReadyReg) begin
                        // Everything the access needs is captured here; the
                        // inputs are not looked at again until IDLE.
                        stateReg    <= ACCESS;
                        reqReadyReg <= 1'b0;
                        busyReg     <= 1'b1;
                        opReg       <= decodeOp(MemRead, MemWrite);
                        indexReg    <= Address[IDX_MSB:IDX_LSB];
                        dataReg     <= WriteData;
                        misalignReg <= reqMisaligned;
                        waitCntReg  <= WAIT_CNT_W'(WAIT_CYCLES);
                    end
                end

                ACCESS: begin
                    if (waitCntReg == '0) begin
                        stateReg     <= RESP;
                        respValidReg <= 1'b1;
                        alignErrReg  <= misalignReg;
                        if ((opReg == OP_LOAD) && !misalignReg) begin
                            readDataReg <= arrRdData;
                        end
                    end else begin
                        waitCntReg <= waitCntReg - 1'b1;
                    end
                end

                RESP: begin
                    stateReg     <= IDLE;
                    respValidReg <= 1'b0;
                    alignErrReg  <= 1'b0;
                    reqReadyReg  <= 1'b1;
                    busyReg      <= 1'b0;
                end

                default: begin
                    stateReg     <= IDLE;
                    respValidReg <= 1'b0;
                    alignErrReg  <= 1'b0;
                    reqReadyReg  <= 1'b1;
                    busyReg      <= 1'b0;
                end
            endcase
        end
    end

    assign ReqReady  = reqReadyReg;
    assign Busy      = busyReg;
    assign RespValid = respValidReg;
    assign ReadData  = readDataReg;
    assign AlignErr  = alignErrReg;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// ---------------------------------------------------------------------------
// tb_data_mem_ctrl
// Self-checking bench for data_mem_ctrl. A word-array reference model is
// updated per request from the load/store rules; every transaction checks
// response latency, pulse width, ReadData and AlignErr. Honours
// DMEM_ALIGN_CHECK_EN for the alignment expectations.
// ---------------------------------------------------------------------------
module tb_data_mem_ctrl;

    localparam int N      = 64;
    localparam int DEPTH  = 256;
    localparam int WAITC  = 2;
    // Acceptance edge T -> RespValid in the (WAITC+2)th cycle after T.
    localparam int LAT    = WAITC + 2;
    // ACCESS (WAITC+1) + RESP (1) + IDLE (1) between acceptances.
    localparam int PERIOD = WAITC + 3;
`ifdef DMEM_ALIGN_CHECK_EN
    localparam bit ALIGN_EN = 1'b1;
`else
    localparam bit ALIGN_EN = 1'b0;
`endif

    logic         Clk;
    logic         Rst_n;
    logic         ReqValid;
    logic         ReqReady;
    logic         MemRead;
    logic         MemWrite;
    logic [N-1:0] Address;
    logic [N-1:0] WriteData;
    logic         RespValid;
    logic [N-1:0] ReadData;
    logic         Busy;
    logic         AlignErr;

    logic [N-1:0] memModel [DEPTH];
    logic [N-1:0] rdModel;
    int           testsRun;
    int           testsFailed;

    data_mem_ctrl #(
        .n           (N),
        .DEPTH       (DEPTH),
        .WAIT_CYCLES (WAITC)
    ) dut (
        .Clk       (Clk),
        .Rst_n     (Rst_n),
        .ReqValid  (ReqValid),
        .ReqReady  (ReqReady),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .Address   (Address),
        .WriteData (WriteData),
        .RespValid (RespValid),
        .ReadData  (ReadData),
        .Busy      (Busy),
        .AlignErr  (AlignErr)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #1000000;
        $display("[TB] FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    function automatic logic [N-1:0] rand64();
        logic [31:0] hi;
        logic [31:0] lo;
        hi = $urandom();
        lo = $urandom();
        return {hi, lo};
    endfunction

    // Issue one request at a negedge while IDLE, scramble the inputs after
    // acceptance, apply the reference-model update and check the response.
    task automatic doTxn(input logic rd, input logic wr, input logic [N-1:0] addr,
                         input logic [N-1:0] wdata, input string tag);
        int  waitCnt;
        int  lat;
        bit  seen;
        bit  mis;
        bit  busyBad;
        int  idx;
        waitCnt = 0;
        while (ReqReady !== 1'b1 && waitCnt < 50) begin
            @(negedge Clk);
            waitCnt++;
        end
        testsRun++;
        if (ReqReady !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL %s ready_wait: ReqReady=%b required 1", tag, ReqReady);
            return;
        end
        ReqValid  = 1'b1;
        MemRead   = rd;
        MemWrite  = wr;
        Address   = addr;
        WriteData = wdata;
        @(posedge Clk);
        @(negedge Clk);
        ReqValid  = 1'b0;
        MemRead   = 1'($urandom);
        MemWrite  = 1'($urandom);
        Address   = rand64();
        WriteData = rand64();

        // Reference model: word index is the byte address divided by 8,
        // wrapped into the array; stores win; misaligned accesses are inert
        // only when the check is built in.
        mis = ALIGN_EN && (addr % 8 != 0);
        idx = int'((addr / 8) % DEPTH);
        if (!mis) begin
            if (wr) memModel[idx] = wdata;
            else if (rd) rdModel = memModel[idx];
        end

        seen    = 1'b0;
        lat     = 0;
        busyBad = 1'b0;
        for (int k = 1; k <= LAT + 6; k++) begin
            if (RespValid === 1'b1) begin
                seen = 1'b1;
                lat  = k;
                break;
            end
            if (Busy !== 1'b1 || ReqReady !== 1'b0) busyBad = 1'b1;
            @(negedge Clk);
        end
        testsRun++;
        if (busyBad) begin
            testsFailed++;
            $display("[TB] FAIL %s busy_flags: Busy/ReqReady wrong while in progress, required 1/0", tag);
        end
        testsRun++;
        if (!seen || lat != LAT) begin
            testsFailed++;
            $display("[TB] FAIL %s resp_latency: got %0d (seen=%0b) required %0d", tag, lat, seen, LAT);
        end
        if (seen) begin
            testsRun++;
            if (ReadData !== rdModel) begin
                testsFailed++;
                $display("[TB] FAIL %s read_data: got %h required %h", tag, ReadData, rdModel);
            end
            testsRun++;
            if (AlignErr !== mis || Busy !== 1'b1 || ReqReady !== 1'b0) begin
                testsFailed++;
                $display("[TB] FAIL %s resp_flags: AlignErr=%b Busy=%b ReqReady=%b required %b/1/0",
                         tag, AlignErr, Busy, ReqReady, mis);
            end
            @(negedge Clk);
            testsRun++;
            if (RespValid !== 1'b0 || AlignErr !== 1'b0 || ReqReady !== 1'b1 || Busy !== 1'b0) begin
                testsFailed++;
                $display("[TB] FAIL %s after_resp: RespValid=%b AlignErr=%b ReqReady=%b Busy=%b required 0/0/1/0",
                         tag, RespValid, AlignErr, ReqReady, Busy);
            end
        end
        $display("[TB] %s rd=%0b wr=%0b addr=%h wdata=%h lat=%0d rdata=%h alignErr_exp=%0b",
                 tag, rd, wr, addr, wdata, lat, ReadData, mis);
    endtask

    task automatic test_reset();
        logic [N-1:0] oldVal;
        bit           respSeen;
        // Reset state while Rst_n is still low.
        testsRun++;
        if (ReqReady !== 1'b1 || RespValid !== 1'b0 || Busy !== 1'b0 ||
            AlignErr !== 1'b0 || ReadData !== '0) begin
            testsFailed++;
            $display("[TB] FAIL reset_state: ReqReady=%b RespValid=%b Busy=%b AlignErr=%b ReadData=%h required 1/0/0/0/0",
                     ReqReady, RespValid, Busy, AlignErr, ReadData);
        end
        @(negedge Clk);
        Rst_n = 1'b1;
        @(negedge Clk);

        oldVal = 64'h0123_4567_89AB_CDEF;
        doTxn(1'b0, 1'b1, 64'h100, oldVal, "reset_prestore");
        doTxn(1'b1, 1'b0, 64'h100, '0, "reset_preload");

        // Start a store and kill it with reset while in ACCESS.
        ReqValid  = 1'b1;
        MemRead   = 1'b0;
        MemWrite  = 1'b1;
        Address   = 64'h100;
        WriteData = 64'hFFFF_0000_FFFF_0000;
        @(posedge Clk);
        @(negedge Clk);
        ReqValid = 1'b0;
        @(negedge Clk);
        Rst_n = 1'b0;
        #1;
        rdModel = '0;
        testsRun++;
        if (ReqReady !== 1'b1 || RespValid !== 1'b0 || Busy !== 1'b0 || ReadData !== '0) begin
            testsFailed++;
            $display("[TB] FAIL reset_midop: ReqReady=%b RespValid=%b Busy=%b ReadData=%h required 1/0/0/0",
                     ReqReady, RespValid, Busy, ReadData);
        end
        @(negedge Clk);
        Rst_n = 1'b1;
        respSeen = 1'b0;
        for (int k = 0; k < 6; k++) begin
            if (RespValid === 1'b1) respSeen = 1'b1;
            @(negedge Clk);
        end
        testsRun++;
        if (respSeen) begin
            testsFailed++;
            $display("[TB] FAIL reset_no_resp: RespValid=1 seen after abort, required 0");
        end
        doTxn(1'b1, 1'b0, 64'h100, '0, "reset_check_load");
        testsRun++;
        if (ReadData !== oldVal) begin
            testsFailed++;
            $display("[TB] FAIL reset_word_kept: got %h required %h", ReadData, oldVal);
        end
    endtask

    task automatic test_fill();
        for (int i = 0; i < DEPTH; i++) begin
            doTxn(1'b0, 1'b1, 64'(i * 8), rand64(), "fill");
        end
    endtask

    task automatic test_store_load();
        doTxn(1'b0, 1'b1, 64'h40, 64'hDEAD_BEEF_CAFE_F00D, "store_0x40");
        doTxn(1'b1, 1'b0, 64'h40, rand64(), "load_0x40");
        testsRun++;
        if (ReadData !== 64'hDEAD_BEEF_CAFE_F00D) begin
            testsFailed++;
            $display("[TB] FAIL store_load: got %h required deadbeefcafef00d", ReadData);
        end
    endtask

    task automatic test_back_to_back();
        int accepts[$];
        bit readyBad;
        bit periodBad;
        int waitCnt;
        readyBad = 1'b0;
        ReqValid = 1'b1;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        Address  = 64'h18;
        for (int cyc = 0; cyc <= 4 * PERIOD; cyc++) begin
            if (ReqReady === 1'b1) accepts.push_back(cyc);
            if (Busy === 1'b1 && ReqReady !== 1'b0) readyBad = 1'b1;
            @(negedge Clk);
        end
        ReqValid = 1'b0;
        periodBad = 1'b0;
        for (int i = 1; i < accepts.size(); i++) begin
            if (accepts[i] - accepts[i-1] != PERIOD) periodBad = 1'b1;
        end
        testsRun++;
        if (accepts.size() != 5 || periodBad) begin
            testsFailed++;
            $display("[TB] FAIL back_to_back_rate: %0d acceptances (spacing ok=%0b) required 5 spaced %0d",
                     accepts.size(), !periodBad, PERIOD);
        end
        testsRun++;
        if (readyBad) begin
            testsFailed++;
            $display("[TB] FAIL back_to_back_ready: ReqReady=1 while Busy, required 0");
        end
        waitCnt = 0;
        while (ReqReady !== 1'b1 && waitCnt < 20) begin
            @(negedge Clk);
            waitCnt++;
        end
        $display("[TB] back_to_back acceptances=%0d period=%0d", accepts.size(), PERIOD);
    endtask

    task automatic test_wrap();
        doTxn(1'b0, 1'b1, 64'h800, 64'h11, "wrap_store_0x800");
        doTxn(1'b1, 1'b0, 64'h0, '0, "wrap_load_0x0");
        testsRun++;
        if (ReadData !== 64'h11) begin
            testsFailed++;
            $display("[TB] FAIL wrap: got %h required 11", ReadData);
        end
    endtask

    task automatic test_both_ops();
        logic [N-1:0] prevRd;
        prevRd = rdModel;
        doTxn(1'b1, 1'b1, 64'h8, 64'h5, "both_ops_store");
        testsRun++;
        if (ReadData !== prevRd) begin
            testsFailed++;
            $display("[TB] FAIL both_ops_rdata_kept: got %h required %h", ReadData, prevRd);
        end
        doTxn(1'b0, 1'b0, 64'h8, 64'h77, "nop");
        doTxn(1'b1, 1'b0, 64'h8, '0, "both_ops_load");
        testsRun++;
        if (ReadData !== 64'h5) begin
            testsFailed++;
            $display("[TB] FAIL both_ops_word: got %h required 5", ReadData);
        end
    endtask

    task automatic test_align();
        logic [N-1:0] prior;
        logic [N-1:0] expWord;
        prior   = memModel[8];
        expWord = ALIGN_EN ? prior : 64'hA5A5_5A5A_1234_8765;
        doTxn(1'b0, 1'b1, 64'h43, 64'hA5A5_5A5A_1234_8765, "align_store_0x43");
        doTxn(1'b1, 1'b0, 64'h40, '0, "align_load_0x40");
        testsRun++;
        if (ReadData !== expWord) begin
            testsFailed++;
            $display("[TB] FAIL align_word8: got %h required %h", ReadData, expWord);
        end
    endtask

    task automatic test_random();
        logic [N-1:0] addr;
        logic [2:0]   ofs;
        logic         rd;
        logic         wr;
        for (int i = 0; i < 80; i++) begin
            addr = rand64();
            ofs  = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b000;
            addr[2:0] = ofs;
            rd = 1'($urandom);
            wr = ($urandom_range(0, 2) == 0);
            doTxn(rd, wr, addr, rand64(), "random");
        end
    endtask

    initial begin
        testsRun    = 0;
        testsFailed = 0;
        rdModel     = '0;
        Rst_n       = 1'b0;
        ReqValid    = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        Address     = '0;
        WriteData   = '0;
        for (int i = 0; i < DEPTH; i++) memModel[i] = '0;
        @(negedge Clk);
        #1;

        test_reset();
        test_fill();
        test_store_load();
        test_back_to_back();
        test_wrap();
        test_both_ops();
        test_align();
        test_random();

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
